// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_ADDR_W : width of a register-file address (32 registers)
//   XLEN       : width of a register-file data word
//   arb_state_t: arbitration priority state
package rf_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic {
    PRIO_A = 1'b0,  // ALU writeback has priority
    PRIO_B = 1'b1   // load writeback forced ahead after starving
  } arb_state_t;

endpackage : rf_write_arbiter_pkg

// File: rtl/rf_starve_counter.sv
// Starvation counter for the load (B) writeback requester.
//   clk          : clock, state updates on posedge
//   rst_n        : synchronous active-low reset
//   i_b_pending  : B is valid with a nonzero destination
//   i_b_grant    : B owns the write port this cycle
//   o_count      : current count of consecutive denied cycles
//   o_limit_next : next count equals STARVE_LIMIT (forces PRIO_B)
module rf_starve_counter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_b_pending,
  input  logic             i_b_grant,
  output logic [CNT_W-1:0] o_count,
  output logic             o_limit_next
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;

  // Any grant or absence of a pending B request restarts the count.
  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
    w_count_next = '0;
    if (i_b_pending && !i_b_grant) begin
      w_count_next = (r_count == LIMIT) ? LIMIT : r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_count <= '0;
    else        r_count <= w_count_next;
  end

  assign o_count      = r_count;
  assign o_limit_next = (w_count_next == LIMIT);

endmodule : rf_starve_counter

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single reg_file write port between ALU writeback (A) and
// load writeback (B). Fixed priority to A with a starvation guard that
// forces a B grant after STARVE_LIMIT consecutive denials. Writes to x0 are
// accepted and dropped without consuming the port.
//   CLK, RESET            : clock; synchronous active-low reset
//   A_VALID/ADDR/DATA     : A request;  A_READY : A accepted (combinational)
//   B_VALID/ADDR/DATA     : B request;  B_READY : B accepted (combinational)
//   WRITE, INADDRESS, IN  : registered reg_file write port
//   InstHIT               : registered, mirrors WRITE
//   STARVED               : registered, high while in PRIO_B
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  A_VALID,
  input  logic [REG_ADDR_W-1:0] A_ADDR,
  input  logic [XLEN-1:0]       A_DATA,
  output logic                  A_READY,
  input  logic                  B_VALID,
  input  logic [REG_ADDR_W-1:0] B_ADDR,
  input  logic [XLEN-1:0]       B_DATA,
  output logic                  B_READY,
  output logic                  WRITE,
  output logic [REG_ADDR_W-1:0] INADDRESS,
  output logic [XLEN-1:0]       IN,
  output logic                  InstHIT,
  output logic                  STARVED
);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic                  r_write;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_data;

  logic w_a_zero, w_b_zero;
  logic w_a_req, w_b_req;
  logic w_grant_a, w_grant_b;
  logic w_limit_next;
  logic [CNT_W-1:0] w_count;

  // Only nonzero destinations compete for the port; x0 requests bypass it.
  assign w_a_zero = (A_ADDR == '0);
  assign w_b_zero = (B_ADDR == '0);
  assign w_a_req  = A_VALID && !w_a_zero;
  assign w_b_req  = B_VALID && !w_b_zero;

  always_comb begin
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_state_next = r_state;
    case (r_state)
      PRIO_A: begin
        w_grant_a = w_a_req;
        w_grant_b = w_b_req && !w_a_req;
        if (w_limit_next) w_state_next = PRIO_B;
      end
      PRIO_B: begin
        w_grant_b = w_b_req;
        w_grant_a = w_a_req && !w_b_req;
        // B withdrawing while starved is tolerated: fall back to A priority.
        if (w_grant_b || !B_VALID) w_state_next = PRIO_A;
      end
      default: w_state_next = PRIO_A;
    endcase
  end

  assign A_READY = RESET && A_VALID && (w_a_zero || w_grant_a);
  assign B_READY = RESET && B_VALID && (w_b_zero || w_grant_b);

  rf_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk          (CLK),
    .rst_n        (RESET),
    .i_b_pending  (w_b_req),
    .i_b_grant    (w_grant_b),
    .o_count      (w_count),
    .o_limit_next (w_limit_next)
  );

  always_ff @(posedge CLK) begin
    // NOTE: address/data registers are reset too, so the reg_file pins start from known zeros.
    if (!RESET) begin
      r_state <= PRIO_A;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_write <= w_grant_a || w_grant_b;
      if (w_grant_a) begin
        r_addr <= A_ADDR;
        r_data <= A_DATA;
      end else if (w_grant_b) begin
        r_addr <= B_ADDR;
        r_data <= B_DATA;
      end
    end
  end

  assign WRITE     = r_write;
  assign InstHIT   = r_write;
  assign INADDRESS = r_addr;
  assign IN        = r_data;
  assign STARVED   = (r_state == PRIO_B);

endmodule : rf_write_arbiter

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        A_VALID, B_VALID;
  logic [4:0]  A_ADDR, B_ADDR;
  logic [31:0] A_DATA, B_DATA;
  logic        A_READY, B_READY;
  logic        WRITE, InstHIT, STARVED;
  logic [4:0]  INADDRESS;
  logic [31:0] IN;

  int total = 0;
  int bad   = 0;

  // Register-file model fed from the raw write port (x0 writes would show up).
  logic [31:0] rf [32];

  rf_write_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
    .InstHIT(InstHIT), .STARVED(STARVED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (WRITE) rf[INADDRESS] <= IN;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    A_VALID = 1'b0; B_VALID = 1'b0;
    A_ADDR = '0; B_ADDR = '0; A_DATA = '0; B_DATA = '0;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    A_VALID = 1'b1; A_ADDR = 5'd9;  A_DATA = 32'h1111;
    B_VALID = 1'b1; B_ADDR = 5'd10; B_DATA = 32'h2222;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      total++; if (A_READY !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", A_READY); end
      total++; if (B_READY !== 1'b0) begin bad++; $display("FAIL reset_b_ready got=%b exp=0", B_READY); end
      @(posedge CLK); #1;
      total++; if (WRITE !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", WRITE); end
      total++; if (InstHIT !== 1'b0) begin bad++; $display("FAIL reset_insthit got=%b exp=0", InstHIT); end
      total++; if (INADDRESS !== 5'd0) begin bad++; $display("FAIL reset_inaddress got=%0d exp=0", INADDRESS); end
      total++; if (IN !== 32'd0) begin bad++; $display("FAIL reset_in got=%h exp=0", IN); end
      total++; if (STARVED !== 1'b0) begin bad++; $display("FAIL reset_starved got=%b exp=0", STARVED); end
    end
    @(negedge CLK);
    idle();
    RESET = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_single_write();
    @(negedge CLK);
    A_VALID = 1'b1; A_ADDR = 5'd5; A_DATA = 32'h0000_005F;
    #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL single_a_ready got=%b exp=1", A_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b1 || InstHIT !== 1'b1) begin bad++; $display("FAIL single_write got=%b/%b exp=1/1", WRITE, InstHIT); end
    total++; if (INADDRESS !== 5'd5) begin bad++; $display("FAIL single_addr got=%0d exp=5", INADDRESS); end
    total++; if (IN !== 32'h5F) begin bad++; $display("FAIL single_data got=%h exp=5f", IN); end
    @(negedge CLK); idle();
    @(posedge CLK); #1;
    total++; if (rf[5] !== 32'h5F) begin bad++; $display("FAIL single_rf_x5 got=%h exp=5f", rf[5]); end
    total++; if (WRITE !== 1'b0) begin bad++; $display("FAIL single_idle_write got=%b exp=0", WRITE); end
  endtask

  task automatic test_contention();
    @(negedge CLK);
    A_VALID = 1'b1; A_ADDR = 5'd1; A_DATA = 32'd28;
    B_VALID = 1'b1; B_ADDR = 5'd2; B_DATA = 32'd50;
    #1;
    total++; if (A_READY !== 1'b1 || B_READY !== 1'b0) begin bad++; $display("FAIL cont_ready1 got=%b%b exp=10", A_READY, B_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b1 || INADDRESS !== 5'd1 || IN !== 32'd28) begin bad++; $display("FAIL cont_first got=%b/%0d/%0d exp=1/1/28", WRITE, INADDRESS, IN); end
    @(negedge CLK);
    A_VALID = 1'b0;
    #1;
    total++; if (B_READY !== 1'b1) begin bad++; $display("FAIL cont_b_ready got=%b exp=1", B_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b1 || INADDRESS !== 5'd2 || IN !== 32'd50) begin bad++; $display("FAIL cont_second got=%b/%0d/%0d exp=1/2/50", WRITE, INADDRESS, IN); end
    @(negedge CLK); idle();
    @(posedge CLK); #1;
    total++; if (rf[1] !== 32'd28 || rf[2] !== 32'd50) begin bad++; $display("FAIL cont_rf got=%0d/%0d exp=28/50", rf[1], rf[2]); end
  endtask

  task automatic test_starvation();
    B_VALID = 1'b1; B_ADDR = 5'd4; B_DATA = 32'hABCD;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      A_VALID = 1'b1; A_ADDR = 5'd3; A_DATA = 32'(i + 1);
      #1;
      total++; if (A_READY !== 1'b1 || B_READY !== 1'b0) begin bad++; $display("FAIL starve_deny%0d got=%b%b exp=10", i, A_READY, B_READY); end
      total++; if (STARVED !== 1'b0) begin bad++; $display("FAIL starve_flag_early%0d got=%b exp=0", i, STARVED); end
      @(posedge CLK); #1;
      total++; if (INADDRESS !== 5'd3 || IN !== 32'(i + 1)) begin bad++; $display("FAIL starve_a_write%0d got=%0d/%0d exp=3/%0d", i, INADDRESS, IN, i + 1); end
    end
    total++; if (STARVED !== 1'b1) begin bad++; $display("FAIL starve_flag got=%b exp=1", STARVED); end
    @(negedge CLK);
    A_DATA = 32'd5;
    #1;
    total++; if (B_READY !== 1'b1 || A_READY !== 1'b0) begin bad++; $display("FAIL starve_force got=a%b b%b exp=a0 b1", A_READY, B_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b1 || INADDRESS !== 5'd4 || IN !== 32'hABCD) begin bad++; $display("FAIL starve_b_write got=%b/%0d/%h exp=1/4/abcd", WRITE, INADDRESS, IN); end
    total++; if (STARVED !== 1'b0 || dut.r_state !== PRIO_A) begin bad++; $display("FAIL starve_back_prio_a got=%b exp=0", STARVED); end
    total++; if (dut.u_starve.o_count !== 4'd0) begin bad++; $display("FAIL starve_count_clear got=%0d exp=0", dut.u_starve.o_count); end
    @(negedge CLK);
    B_VALID = 1'b0;
    #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL starve_a_resume got=%b exp=1", A_READY); end
    @(posedge CLK); #1;
    total++; if (INADDRESS !== 5'd3 || IN !== 32'd5) begin bad++; $display("FAIL starve_a_final got=%0d/%0d exp=3/5", INADDRESS, IN); end
    @(negedge CLK); idle();
    @(posedge CLK); #1;
  endtask

  task automatic test_x0();
    @(negedge CLK);
    A_VALID = 1'b1; A_ADDR = 5'd0; A_DATA = 32'hFFFF_FFFF;
    B_VALID = 1'b1; B_ADDR = 5'd6; B_DATA = 32'd108;
    #1;
    total++; if (A_READY !== 1'b1 || B_READY !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b%b exp=11", A_READY, B_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b1 || INADDRESS !== 5'd6 || IN !== 32'd108) begin bad++; $display("FAIL x0_b_write got=%b/%0d/%0d exp=1/6/108", WRITE, INADDRESS, IN); end
    // Both to x0: both accepted, no write, port registers hold.
    @(negedge CLK);
    B_ADDR = 5'd0; B_DATA = 32'h1234;
    #1;
    total++; if (A_READY !== 1'b1 || B_READY !== 1'b1) begin bad++; $display("FAIL x0_both_ready got=%b%b exp=11", A_READY, B_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b0 || InstHIT !== 1'b0) begin bad++; $display("FAIL x0_both_write got=%b/%b exp=0/0", WRITE, InstHIT); end
    total++; if (INADDRESS !== 5'd6 || IN !== 32'd108) begin bad++; $display("FAIL x0_hold got=%0d/%0d exp=6/108", INADDRESS, IN); end
    total++; if (rf[0] !== 32'd0 || rf[6] !== 32'd108) begin bad++; $display("FAIL x0_rf got=%h/%0d exp=0/108", rf[0], rf[6]); end
    @(negedge CLK); idle();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    A_VALID = 1'b1; A_ADDR = 5'd7; A_DATA = 32'd15;
    B_VALID = 1'b1; B_ADDR = 5'd9; B_DATA = 32'd77;
    #1;
    total++; if (A_READY !== 1'b1) begin bad++; $display("FAIL mid_a_ready got=%b exp=1", A_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b1 || INADDRESS !== 5'd7 || IN !== 32'd15) begin bad++; $display("FAIL mid_grant got=%b/%0d/%0d exp=1/7/15", WRITE, INADDRESS, IN); end
    total++; if (dut.u_starve.o_count !== 4'd1) begin bad++; $display("FAIL mid_count_pre got=%0d exp=1", dut.u_starve.o_count); end
    @(negedge CLK);
    RESET = 1'b0;
    A_ADDR = 5'd8; A_DATA = 32'd99;
    #1;
    total++; if (A_READY !== 1'b0 || B_READY !== 1'b0) begin bad++; $display("FAIL mid_ready_in_reset got=%b%b exp=00", A_READY, B_READY); end
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b0 || InstHIT !== 1'b0) begin bad++; $display("FAIL mid_write got=%b/%b exp=0/0", WRITE, InstHIT); end
    total++; if (INADDRESS !== 5'd0 || IN !== 32'd0) begin bad++; $display("FAIL mid_port got=%0d/%0d exp=0/0", INADDRESS, IN); end
    total++; if (dut.u_starve.o_count !== 4'd0 || dut.r_state !== PRIO_A || STARVED !== 1'b0) begin bad++; $display("FAIL mid_state got=cnt%0d st%b exp=cnt0 st0", dut.u_starve.o_count, STARVED); end
    @(negedge CLK);
    idle();
    RESET = 1'b1;
    @(posedge CLK); #1;
    total++; if (WRITE !== 1'b0) begin bad++; $display("FAIL mid_after_write got=%b exp=0", WRITE); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    idle();
    RESET = 1'b0;
    test_reset();
    test_single_write();
    test_contention();
    test_starvation();
    test_x0();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_write_arbiter

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources.
  - Requester A: ALU writeback, nominal priority.
  - Requester B: load writeback, variable latency.
- Sits between the writeback stage and reg_file, and drives reg_file's WRITE, INADDRESS, IN and InstHIT pins from a registered output stage.
- Fixed priority to A, with a starvation guard that forces a B grant after a bounded wait. Writes to x0 are absorbed without using the port.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles B may be denied before B gets forced priority; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET  in  1  synchronous, active-low reset.
- A_VALID  in  1  A has a write request.
- A_ADDR  in  5  A destination register.
- A_DATA  in  32  A write data.
- A_READY  out  1  A request accepted this cycle (combinational).
- B_VALID  in  1  B has a write request.
- B_ADDR  in  5  B destination register.
- B_DATA  in  32  B write data.
- B_READY  out  1  B request accepted this cycle (combinational).
- WRITE  out  1  registered write enable to reg_file.
- INADDRESS  out  5  registered write address.
- IN  out  32  registered write data.
- InstHIT  out  1  registered; equals WRITE.
- STARVED  out  1  registered; high while in state PRIO_B.

Behaviour:
- Reset: RESET sampled low at posedge clears all state.
  - WRITE=0, InstHIT=0, INADDRESS=0, IN=0, STARVED=0, counter=0, state=PRIO_A.
  - While RESET is low, A_READY=0 and B_READY=0 regardless of VALID.
- Handshake:
  - A transfer occurs at a posedge where VALID&READY=1.
  - The requester holds ADDR/DATA stable until accepted.
  - READY never depends on the requester's own ADDR except for the x0 rule below.
- x0 rule: a valid request with ADDR=0 is always accepted (READY=1) and produces no write. It does not consume the port, so the other requester may be granted in the same cycle.
- State machine:
  - PRIO_A: port goes to A if A is valid with a nonzero address; otherwise to B if B is valid with a nonzero address.
  - PRIO_B: port goes to B if valid and nonzero; otherwise to A.
- Starvation counter:
  - Increments each cycle B is valid with a nonzero address and is not granted.
  - Clears to 0 on any B grant, and whenever B is not valid.
  - Saturates at STARVE_LIMIT.
- Transitions:
  - PRIO_A -> PRIO_B at the edge where the counter's next value equals STARVE_LIMIT.
  - PRIO_B -> PRIO_A at the edge where B is granted, or B_VALID is low (B withdrew; protocol violation, tolerated).
- Output stage:
  - On a non-x0 grant at edge N: WRITE=InstHIT=1 during cycle N+1, with INADDRESS/IN set to the granted addr/data. reg_file commits at edge N+1.
  - No grant: WRITE=InstHIT=0, and INADDRESS/IN hold their previous values.
  - Latency from accept to regfile commit is exactly 1 cycle. Throughput is 1 write per cycle.
- Simultaneous same-address requests: only one is granted per cycle. Program order is the order of grants, so the later grant's value wins in the regfile. Ordering across requesters is the writeback stage's responsibility.
- Both requests to x0: both accepted, WRITE=0 next cycle.
- Reset mid-operation: any pending output write is dropped (WRITE=0 next cycle), and any request asserted during reset must be re-presented after reset.

Decomposition:
- Shared package: REG_ADDR_W=5, XLEN=32, and a state enum {PRIO_A, PRIO_B}.
- One natural sub-module, rf_starve_counter: counter, saturation, and the limit-reached flag. Arbitration and the output register stay in the top module.

Test Plan:
- Reset: hold RESET=0 for 2 cycles with A_VALID=B_VALID=1 -> A_READY=B_READY=0, and WRITE=InstHIT=0, INADDRESS=0, IN=0 after the edge.
- Single write: A_VALID=1, A_ADDR=5, A_DATA=0x0000_005F for 1 cycle -> A_READY=1. Next cycle WRITE=1, INADDRESS=5, IN=0x5F; reg_file x5 reads 0x5F afterwards.
- Contention: A and B both valid (A: x1=28, B: x2=50) -> A granted first, then B. WRITE is high for 2 consecutive cycles with addresses 1 then 2.
- Starvation: A valid every cycle (x3, incrementing data), B valid (x4=0xABCD), STARVE_LIMIT=4.
  - B is denied 4 cycles; STARVED=1.
  - Next cycle B_READY=1 and A_READY=0, then INADDRESS=4, IN=0xABCD.
  - Counter and state return to PRIO_A.
- x0 absorption: A_ADDR=0 with A_DATA=0xFFFF_FFFF, and B_ADDR=6 with B_DATA=108, same cycle -> both READY=1. Next cycle WRITE=1, INADDRESS=6, IN=108; x0 stays 0.
- Reset mid-operation: grant A (x7=15), then drop RESET low on the following edge -> WRITE=0 after that edge, counter=0, state=PRIO_A; no READY while RESET is low.
